// File: rtl/fpaddsub_pipe.sv
// fpaddsub_pipe: pipelined floating-point add/subtract, round-to-nearest-even, flush-to-zero.
// Operand register, then align, add/normalise and round/pack stages sharing one stall enable.
module fpaddsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 ovf,
    output logic                 inv
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int AW  = MAN_W + 4;              // hidden, fraction, guard, round, sticky
    localparam int CAP = MAN_W + 3;
    localparam int XW  = MAN_W + 1 + CAP;
    localparam int EW  = EXP_W + $clog2(AW + 1) + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic signed [EW-1:0] EF_MAX  = {{(EW-EXP_W){1'b0}}, EMAX};
    localparam logic signed [EW-1:0] EF_ZERO = '0;

    function automatic int lzc(input logic [AW-1:0] v);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        for (int i = AW - 1; i >= 0; i--) begin
            if (v[i]) seen = 1'b1;
            else if (!seen) n = n + 1;
        end
        return n;
    endfunction

    function automatic logic [MAN_W+1:0] round_rne(input logic [AW-1:0] m);
        logic up;
        up = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[AW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    endfunction

    logic en;
    logic vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;

    assign en        = !vld_p3_q | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else if (en) begin
            vld_p0_q <= in_valid;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
        end
    end

    // operand capture
    logic [W-1:0] a_p0_q, b_p0_q;
    logic         sub_p0_q;

    always_ff @(posedge clk) begin
        if (en) begin
            a_p0_q   <= a;
            b_p0_q   <= b;
            sub_p0_q <= sub;
        end
    end

    // S1: classify, order by magnitude, align the smaller operand
    logic             sa, sb, swap, a_inf, a_nan, b_inf, b_nan;
    logic [EXP_W-1:0] ea, eb, ediff;
    logic [W-2:0]     mag_a, mag_b, mag_x, mag_y;
    logic [XW-1:0]    ext;
    int               shamt;
    logic             sx_d, esub_d, nan1_d, inf1_d;
    logic [EXP_W-1:0] ex_d;
    logic [AW-1:0]    xm_d, ym_d;

    always_comb begin
        sa     = a_p0_q[W-1];
        sb     = b_p0_q[W-1] ^ sub_p0_q;
        ea     = a_p0_q[W-2:MAN_W];
        eb     = b_p0_q[W-2:MAN_W];
        a_inf  = (ea == EMAX) && (a_p0_q[MAN_W-1:0] == '0);
        a_nan  = (ea == EMAX) && (a_p0_q[MAN_W-1:0] != '0);
        b_inf  = (eb == EMAX) && (b_p0_q[MAN_W-1:0] == '0);
        b_nan  = (eb == EMAX) && (b_p0_q[MAN_W-1:0] != '0);
        mag_a  = (ea == '0) ? '0 : a_p0_q[W-2:0];
        mag_b  = (eb == '0) ? '0 : b_p0_q[W-2:0];
        swap   = mag_b > mag_a;
        mag_x  = swap ? mag_b : mag_a;
        mag_y  = swap ? mag_a : mag_b;
        sx_d   = swap ? sb : sa;
        esub_d = sa ^ sb;
        ex_d   = mag_x[W-2:MAN_W];
        ediff  = ex_d - mag_y[W-2:MAN_W];
        shamt  = (int'(ediff) > CAP) ? CAP : int'(ediff);
        ext    = {(mag_y[W-2:MAN_W] != '0), mag_y[MAN_W-1:0], {CAP{1'b0}}} >> shamt;
        xm_d   = {(ex_d != '0), mag_x[MAN_W-1:0], 3'b000};
        ym_d   = {ext[XW-1:CAP], ext[CAP-1], ext[CAP-2], |ext[CAP-3:0]};
        nan1_d = a_nan | b_nan | (a_inf & b_inf & esub_d);
        inf1_d = (a_inf | b_inf) & !nan1_d;
    end

    logic             sx_p1_q, esub_p1_q, nan_p1_q, inf_p1_q;
    logic [EXP_W-1:0] ex_p1_q;
    logic [AW-1:0]    xm_p1_q, ym_p1_q;

    always_ff @(posedge clk) begin
        if (en) begin
            sx_p1_q   <= sx_d;
            esub_p1_q <= esub_d;
            nan_p1_q  <= nan1_d;
            inf_p1_q  <= inf1_d;
            ex_p1_q   <= ex_d;
            xm_p1_q   <= xm_d;
            ym_p1_q   <= ym_d;
        end
    end

    // S2: add or subtract magnitudes, then normalise
    logic [AW:0]          sum;
    int                   lz;
    logic signed [EW-1:0] ex_s, exp_d;
    logic [AW-1:0]        man_d;
    logic                 zero_d, zsgn_d;

    always_comb begin
        sum    = esub_p1_q ? ({1'b0, xm_p1_q} - {1'b0, ym_p1_q})
                           : ({1'b0, xm_p1_q} + {1'b0, ym_p1_q});
        lz     = lzc(sum[AW-1:0]);
        ex_s   = {{(EW-EXP_W){1'b0}}, ex_p1_q};
        if (sum[AW]) begin
            man_d = {sum[AW:2], sum[1] | sum[0]};
            exp_d = ex_s + EW'(1);
        end else begin
            man_d = sum[AW-1:0] << lz;
            exp_d = ex_s - EW'(lz);
        end
        zero_d = (sum == '0);
        zsgn_d = !esub_p1_q & sx_p1_q;
    end

    logic                 sgn_p2_q, zero_p2_q, zsgn_p2_q, nan_p2_q, inf_p2_q;
    logic signed [EW-1:0] exp_p2_q;
    logic [AW-1:0]        man_p2_q;

    always_ff @(posedge clk) begin
        if (en) begin
            sgn_p2_q  <= sx_p1_q;
            zero_p2_q <= zero_d;
            zsgn_p2_q <= zsgn_d;
            nan_p2_q  <= nan_p1_q;
            inf_p2_q  <= inf_p1_q;
            exp_p2_q  <= exp_d;
            man_p2_q  <= man_d;
        end
    end

    // S3: round, then resolve specials, overflow and underflow flush
    logic [MAN_W+1:0]     mr;
    logic signed [EW-1:0] ef;
    logic [MAN_W-1:0]     frac;
    logic [W-1:0]         result_d;
    logic                 ovf_d, inv_d;

    always_comb begin
        mr       = round_rne(man_p2_q);
        ef       = exp_p2_q + (mr[MAN_W+1] ? EW'(1) : EW'(0));
        frac     = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        result_d = {sgn_p2_q, ef[EXP_W-1:0], frac};
        ovf_d    = 1'b0;
        inv_d    = 1'b0;
        if (nan_p2_q) begin
            result_d = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
            inv_d    = 1'b1;
        end else if (inf_p2_q) begin
            result_d = {sgn_p2_q, EMAX, {MAN_W{1'b0}}};
        end else if (zero_p2_q) begin
            result_d = {zsgn_p2_q, {(W-1){1'b0}}};
        end else if (ef >= EF_MAX) begin
            result_d = {sgn_p2_q, EMAX, {MAN_W{1'b0}}};
            ovf_d    = 1'b1;
        end else if (ef <= EF_ZERO) begin
            result_d = {sgn_p2_q, {(W-1){1'b0}}};
        end
    end

    logic [W-1:0] result_p3_q;
    logic         ovf_p3_q, inv_p3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p3_q <= '0;
            ovf_p3_q    <= 1'b0;
            inv_p3_q    <= 1'b0;
        end else if (en) begin
            result_p3_q <= result_d;
            ovf_p3_q    <= ovf_d;
            inv_p3_q    <= inv_d;
        end
    end

    assign result = result_p3_q;
    assign ovf    = ovf_p3_q;
    assign inv    = inv_p3_q;
endmodule

// File: tb/tb_fpaddsub_pipe.sv
// tb_fpaddsub_pipe: scoreboard bench for fpaddsub_pipe in binary32, plus a binary16 instance.
module tb_fpaddsub_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready, ovf, inv;
    logic [31:0] a, b, result;

    logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready, h_ovf, h_inv;
    logic [15:0] h_a, h_b, h_result;

    fpaddsub_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .inv(inv)
    );

    fpaddsub_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .sub(h_sub),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .ovf(h_ovf), .inv(h_inv)
    );

    typedef struct {
        string       tag;
        logic [33:0] want;   // {ovf, inv, result}
        int          acc;    // edge index at which the operands were accepted
        bit          lat;    // latency is checked only for unstalled traffic
    } sb_t;

    sb_t         sbq[$];
    sb_t         e;
    int          n_vec = 0;
    int          n_miscmp = 0;
    int          cyc = 0;
    logic [31:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [33:0] got, input logic [33:0] want);
        n_vec++;
        if (got !== want) begin
            n_miscmp++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk_val("spurious_out", {33'd0, out_valid}, 34'd0);
            end else begin
                e = sbq.pop_front();
                chk_val(e.tag, {ovf, inv, result}, e.want);
                if (e.lat) chk_val({e.tag, "_lat"}, 34'(cyc - e.acc), 34'd3);
            end
        end
    end

    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                         input logic [33:0] want, input string tag, input bit lat);
        sb_t s;
        int  guard;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        sub      = vs;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk_val({tag, "_accept"}, {33'd0, in_ready}, 34'd1);
        end else begin
            s.tag  = tag;
            s.want = want;
            s.acc  = cyc + 1;
            s.lat  = lat;
            sbq.push_back(s);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sbq.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk_val({tag, "_drain"}, 34'(sbq.size()), 34'd0);
        sbq.delete();
    endtask

    task automatic run16(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         input logic [18:0] want, input string tag);
        int guard;
        h_in_valid = 1'b1;
        h_a        = va;
        h_b        = vb;
        h_sub      = vs;
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        guard      = 0;
        @(negedge clk);
        while (!h_out_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk_val(tag, 34'({h_out_valid, h_ovf, h_inv, h_result}), 34'(want));
        chk_val({tag, "_lat"}, 34'(guard), 34'd3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_sub = 1'b0; h_out_ready = 1'b1;
        held = '0;
        @(posedge clk);
        #1;
        chk_val("rst_out_valid", {33'd0, out_valid}, 34'd0);
        chk_val("rst_result", {ovf, inv, result}, 34'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk_val("rst_in_ready", {33'd0, in_ready}, 34'd1);
        @(posedge clk);
        #1;

        // back-to-back stream with out_ready held high
        drive(32'h3f115b57, 32'h3fab851f, 1'b0, {2'b00, 32'h3ff432ca}, "add_mixed", 1);
        drive(32'h3f800000, 32'h3f800000, 1'b0, {2'b00, 32'h40000000}, "add_one_one", 1);
        drive(32'h00000000, 32'h3fab851f, 1'b0, {2'b00, 32'h3fab851f}, "add_zero", 1);
        drive(32'h40000000, 32'h3f800000, 1'b1, {2'b00, 32'h3f800000}, "sub_two_one", 1);
        drive(32'h3f800000, 32'h3f800000, 1'b1, {2'b00, 32'h00000000}, "sub_equal", 1);
        drive(32'h80000000, 32'h80000000, 1'b0, {2'b00, 32'h80000000}, "neg_zeros", 1);
        drive(32'h3f800000, 32'h33800000, 1'b0, {2'b00, 32'h3f800000}, "tie_even", 1);
        drive(32'h3f800001, 32'h33800000, 1'b0, {2'b00, 32'h3f800002}, "tie_odd", 1);
        drive(32'h7f800000, 32'hff800000, 1'b0, {2'b01, 32'h7fc00000}, "inf_minus_inf", 1);
        drive(32'h7fc12345, 32'h3f800000, 1'b0, {2'b01, 32'h7fc00000}, "nan_in", 1);
        drive(32'h7f7fffff, 32'h7f7fffff, 1'b0, {2'b10, 32'h7f800000}, "overflow", 1);
        drive(32'h00400000, 32'h00000000, 1'b0, {2'b00, 32'h00000000}, "denorm_flush", 1);
        drive(32'h7f800000, 32'h3f800000, 1'b0, {2'b00, 32'h7f800000}, "inf_plus_fin", 1);
        drive(32'h3f800000, 32'h7f800000, 1'b1, {2'b00, 32'hff800000}, "fin_minus_inf", 1);
        drive(32'h3f800000, 32'hbf800000, 1'b0, {2'b00, 32'h00000000}, "x_plus_negx", 1);
        drive(32'hbf800000, 32'hbf800000, 1'b1, {2'b00, 32'h00000000}, "negx_minus_negx", 1);
        drive(32'hc0000000, 32'h3f800000, 1'b0, {2'b00, 32'hbf800000}, "neg_result", 1);
        drive(32'h3f800000, 32'h40400000, 1'b0, {2'b00, 32'h40800000}, "swap_larger_b", 1);
        drive(32'h3f800000, 32'h00800000, 1'b0, {2'b00, 32'h3f800000}, "far_align", 1);
        drive(32'h3f800000, 32'h33800000, 1'b1, {2'b00, 32'h3f7fffff}, "cancel_norm", 1);
        drive(32'h3fffffff, 32'h33800000, 1'b0, {2'b00, 32'h40000000}, "round_carry", 1);
        drive(32'h00800001, 32'h00800000, 1'b1, {2'b00, 32'h00000000}, "underflow", 1);
        drive(32'h3f800000, 32'hffc00001, 1'b1, {2'b01, 32'h7fc00000}, "nan_b_sub", 1);
        drain("b2b");

        // backpressure: stall the consumer for four cycles mid-stream
        @(posedge clk);
        #1;
        fork
            begin
                drive(32'h3f800000, 32'h3f800000, 1'b0, {2'b00, 32'h40000000}, "bp0", 0);
                drive(32'h40000000, 32'h3f800000, 1'b0, {2'b00, 32'h40400000}, "bp1", 0);
                drive(32'h40400000, 32'h3f800000, 1'b0, {2'b00, 32'h40800000}, "bp2", 0);
                drive(32'h40800000, 32'h3f800000, 1'b0, {2'b00, 32'h40a00000}, "bp3", 0);
                drive(32'h40a00000, 32'h3f800000, 1'b0, {2'b00, 32'h40c00000}, "bp4", 0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (i == 0) held = result;
                    else chk_val("stall_result", {2'b00, result}, {2'b00, held});
                    chk_val("stall_in_ready", {33'd0, in_ready}, 34'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp");

        // reset with two operations in flight
        @(posedge clk);
        #1;
        drive(32'h3f800000, 32'h3f800000, 1'b0, {2'b00, 32'h40000000}, "rst_a", 0);
        drive(32'h40000000, 32'h3f800000, 1'b0, {2'b00, 32'h40400000}, "rst_b", 0);
        repeat (2) @(posedge clk);
        #2;
        chk_val("pre_rst_valid", {33'd0, out_valid}, 34'd1);
        rst_n = 1'b0;
        #1;
        chk_val("mid_rst_out_valid", {33'd0, out_valid}, 34'd0);
        sbq.delete();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_val("post_rst_idle", {33'd0, out_valid}, 34'd0);
        end
        @(posedge clk);
        #1;

        // binary16 instance
        run16(16'h3c00, 16'h3c00, 1'b0, {3'b100, 16'h4000}, "h16_one_plus_one");
        run16(16'h7bff, 16'h7bff, 1'b0, {3'b110, 16'h7c00}, "h16_overflow");
        run16(16'h3c00, 16'h3c00, 1'b1, {3'b100, 16'h0000}, "h16_sub_equal");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule

// File: doc/fpaddsub_pipe.md
# fpaddsub_pipe

Parametrised, pipelined floating-point adder/subtractor for the lvg FP unit; next generation of the combinational `fpadd`. Accepts one operand pair per cycle through a valid/ready handshake and returns the IEEE-754-style sum or difference three cycles later. Rounding is round-to-nearest-even, with canonical NaN, infinity, overflow and flush-to-zero handling. Default parameters give binary32; other widths serve reduced-precision datapaths.

## Interface
- `EXP_W`, 8: exponent field width (≥3).
- `MAN_W`, 23: stored mantissa width, hidden bit excluded (≥2).
- Derived: `W = 1 + EXP_W + MAN_W`; `BIAS = 2^(EXP_W-1) - 1`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: block accepts this cycle.
- `a` in W: operand A.
- `b` in W: operand B.
- `sub` in 1: 1 gives A − B; 0 gives A + B.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts.
- `result` out W: packed result.
- `ovf` out 1: finite overflow rounded to infinity. Valid with `out_valid`.
- `inv` out 1: invalid operation (NaN operand or ∞ − ∞). Valid with `out_valid`.

## Operation
- Effective B sign is `b[W-1] ^ sub`.
- Exponent field 0 denotes zero. Denormal inputs are flushed to zero with their sign kept.
- **S1, unpack/align:**
  - Decode class: zero, normal, inf, NaN.
  - Swap so the larger magnitude is X; compare exponent first, then mantissa.
  - Right-shift the smaller mantissa by the exponent difference, capped at MAN_W+3.
  - Keep guard and round bits; OR everything shifted past them into sticky.
- **S2, add/normalise:**
  - Add mantissas on equal signs, subtract on unequal signs.
  - On carry-out, shift right 1 (bit lost ORs into sticky) and increment the exponent.
  - Otherwise apply a leading-zero count and left shift, decrementing the exponent.
  - An exact-zero magnitude yields a zero result.
- **S3, round/pack:**
  - Round up when G & (R | S | LSB).
  - A mantissa carry from rounding increments the exponent.
  - Exponent ≥ all-ones gives ±inf with `ovf=1`.
  - Exponent ≤ 0 gives signed zero (flush; no flag).
- **Specials:**
  - Any NaN operand gives canonical NaN (sign 0, exp all-ones, mantissa MSB 1, rest 0) with `inv=1`.
  - ∞ + (−∞) gives canonical NaN with `inv=1`.
  - ∞ ± finite gives that ∞; `ovf=0`.
- **Zero sign:**
  - x + (−x) gives +0.
  - (−0) + (−0) gives −0.
  - Other exact zeros take the sign of X.

## Timing
- Reset values:
  - All stage valid bits 0, so `out_valid=0`.
  - `result=0`, `ovf=0`, `inv=0`.
  - `in_ready=1` once reset is released.
- Global enable: `en = !out_valid | out_ready`; `in_ready = en`. Combinational from `out_ready` and internal state only, never from `in_valid`.
- An input transfer occurs when `in_valid & in_ready`. An output transfer occurs when `out_valid & out_ready`.
- Latency: 3 cycles. An operand accepted at edge N is visible with `out_valid=1` after edge N+3, provided `en` stays 1.
- Throughput: 1 result per cycle. Order is preserved.
- Stall (`out_valid & !out_ready`):
  - All stages hold.
  - `result`, `ovf` and `inv` stay stable.
  - `in_ready=0`.
  - Bubbles are not collapsed.
- While `en=1`, a stage with no transfer into it takes valid=0. Data registers are don't-care when their valid bit is 0.
- Simultaneous output and input transfer in the same cycle is legal and loses nothing.
- Asserting `rst_n` low mid-operation discards in-flight operations immediately, with no output.

## Test plan
- Back-to-back adds, `sub=0`, with `out_ready=1`:
  - 3f115b57+3fab851f → 3ff432ca
  - 3f800000+3f800000 → 40000000
  - 00000000+3fab851f → 3fab851f
  - Results appear on consecutive cycles, each 3 cycles after its input.
- Subtracts:
  - 40000000−3f800000 → 3f800000
  - 3f800000−3f800000 → 00000000 (+0)
  - 80000000+80000000 → 80000000
- Rounding ties:
  - 3f800000+33800000 → 3f800000 (to even)
  - 3f800001+33800000 → 3f800002
- Specials:
  - 7f800000+ff800000 → 7fc00000 with inv=1
  - 7fc12345+3f800000 → 7fc00000 with inv=1
  - 7f7fffff+7f7fffff → 7f800000 with ovf=1
  - 00400000+00000000 → 00000000 (denormal flushed)
- Backpressure:
  - Stream 5 operands and hold `out_ready=0` for 4 cycles mid-stream.
  - During the stall: `in_ready=0` and `result` is stable.
  - All 5 results appear in order; none is lost or duplicated.
- Reset while 2 operations are in flight → `out_valid=0` immediately and no stale result after release. Also run a directed binary16 subset with `EXP_W=5`, `MAN_W=10`: 3c00+3c00 → 4000 and 7bff+7bff → 7c00 with ovf=1.
